floppy_track_loader: RTL and testbench
======================================

FLOPPY_TRACK_LOADER -- requirements
Module: floppy_track_loader

Interface
REQ-001 The module SHALL have parameter DRIVES, default 2, giving the number of independent floppy drives (1..4).
REQ-002 The module SHALL have parameter SECS, default 13, giving the number of 256-byte sectors per track (1..16).
REQ-003 The module SHALL have parameter TW, default 6, giving the track-number width.
REQ-004 The module SHALL have port clk_sys, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port track, input, DRIVES*TW bits: the current head track per drive, with drive d at [d*TW +: TW].
REQ-007 The module SHALL have port img_mounted, input, DRIVES bits: a one-cycle pulse per drive when a new image is mounted.
REQ-008 The module SHALL have port img_present, input, DRIVES bits: high when the drive's image size is non-zero.
REQ-009 The module SHALL have port fd_write, input, DRIVES bits: a one-cycle pulse when the disk controller writes a byte into the drive's track buffer.
REQ-010 The module SHALL have port sd_ack, input, 1 bit: the storage acknowledge, which is high while a sector transfer is in progress.
REQ-011 The module SHALL have port sd_lba, output, 32 bits: the sector address of the current request.
REQ-012 The module SHALL have port sd_rd, output, 1 bit: the read request.
REQ-013 The module SHALL have port sd_wr, output, 1 bit: the write request.
REQ-014 The module SHALL have port drive_sel, output, $clog2(DRIVES) bits (minimum 1): the drive being serviced.
REQ-015 The module SHALL have port track_sec, output, 4 bits: the sector index within the track, used as the buffer RAM high address.
REQ-016 The module SHALL have port cpu_wait, output, 1 bit: a CPU stall request.
REQ-017 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 The module SHALL keep, per drive: cur_track (TW bits), loaded (1 bit), dirty (1 bit) and mnt_pend (1 bit).
REQ-019 An img_mounted pulse SHALL set mnt_pend and clear dirty for that drive (a new image discards pending writes), in any state.
REQ-020 An fd_write pulse SHALL set dirty for that drive when loaded is high; a simultaneous fd_write and img_mounted SHALL leave dirty at 0.
REQ-021 A drive SHALL need service when img_present is high and either mnt_pend is high or track differs from cur_track.
REQ-022 The state machine SHALL have states IDLE, ARB, REQ, WAIT_HI, WAIT_LO and NEXT.
REQ-023 IDLE: when any drive needs service, the module SHALL go to ARB; when none does, it SHALL stay in IDLE.
REQ-024 ARB: the module SHALL select the lowest-index drive needing service and latch it into drive_sel.
REQ-025 ARB: if the selected drive is dirty and loaded and has no mnt_pend, the module SHALL set op to WRITE, taking the LBA base from the old cur_track.
REQ-026 ARB: otherwise the module SHALL set op to READ, latch cur_track from track, and clear mnt_pend.
REQ-027 ARB: the module SHALL set track_sec to 0 and go to REQ.
REQ-028 sd_lba SHALL equal the zero-extended value of base_track*SECS + track_sec, computed in 32 bits without truncation.
REQ-029 REQ: the module SHALL assert sd_rd or sd_wr according to op, assert cpu_wait, and go to WAIT_HI.
REQ-030 WAIT_HI: on a rising edge of sd_ack (prior sample 0, current sample 1), the module SHALL deassert sd_rd and sd_wr and go to WAIT_LO.
REQ-031 WAIT_LO: on a falling edge of sd_ack, the module SHALL go to NEXT.
REQ-032 NEXT, when track_sec < SECS-1: the module SHALL increment track_sec and go to REQ.
REQ-033 NEXT after the last sector of a WRITE pass: the module SHALL clear dirty, set op to READ, latch cur_track from track, clear mnt_pend, reset track_sec to 0 and go to REQ.
REQ-034 NEXT after the last sector of a READ pass: the module SHALL set loaded, deassert cpu_wait and go to IDLE.
REQ-035 A track change during a transfer SHALL NOT abort the pass; it SHALL be detected in the following IDLE.
REQ-036 img_present falling mid-pass SHALL NOT abort the pass; loaded SHALL be cleared when the pass returns to IDLE.
REQ-037 An sd_ack already high on entry to WAIT_HI SHALL NOT count as an edge.
REQ-038 sd_rd and sd_wr SHALL never be high in the same cycle.
REQ-039 Total latency for a clean drive SHALL be exactly SECS request/ack cycles, and for a dirty drive 2*SECS.

Reset
REQ-040 While reset_n is low, the module SHALL clear asynchronously: state to IDLE, sd_rd, sd_wr, cpu_wait, busy, track_sec, drive_sel, sd_lba (all 0), and every cur_track, loaded, dirty and mnt_pend to 0.
REQ-041 Reset asserted mid-operation SHALL abandon the pass without any further sd_rd or sd_wr pulse.

Verification
REQ-042 Scenario: DRIVES=2, SECS=13, drive0 img_present=1, track 0->5 -> reads with sd_lba 65..77 in order, each sd_rd dropped on ack rise, cpu_wait high throughout, then busy=0 and loaded0=1.
REQ-043 Scenario: drive0 loaded at track 5, one fd_write pulse, track ->6 -> writes with sd_lba 65..77, then reads with sd_lba 78..90, then dirty0=0.
REQ-044 Scenario: both drives need service in the same cycle -> drive 0 is serviced fully (drive_sel=0), then drive 1 (drive_sel=1).
REQ-045 Scenario: img_mounted on a dirty drive with the track unchanged -> no writes, 13 reads of the same track.
REQ-046 Scenario: reset_n pulsed low during WAIT_LO of sector 4 -> all outputs 0 immediately, and no request is issued until a new service need arises.
REQ-047 Scenario: SECS=16, track 63 -> the last sd_lba is 1023 and track_sec wraps only via the NEXT state, never to 16.

Source files
------------

// File: rtl/floppy_track_loader.sv
// Floppy track loader: mirrors whole tracks between each drive's track buffer and
// block storage, and writes a modified track back before reading the newly selected one.
module floppy_track_loader #(
    parameter  int DRIVES = 2,
    parameter  int SECS   = 13,
    parameter  int TW     = 6,
    localparam int SELW   = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [DRIVES*TW-1:0] track,
    input  logic [DRIVES-1:0]    img_mounted,
    input  logic [DRIVES-1:0]    img_present,
    input  logic [DRIVES-1:0]    fd_write,
    input  logic                 sd_ack,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic [SELW-1:0]      drive_sel,
    output logic [3:0]           track_sec,
    output logic                 cpu_wait,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_REQ, S_WAIT_HI, S_WAIT_LO, S_NEXT
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_cur_track [DRIVES];
    logic [DRIVES-1:0] r_loaded;
    logic [DRIVES-1:0] r_dirty;
    logic [DRIVES-1:0] r_mnt_pend;
    logic              r_op_wr;
    logic              r_rd;
    logic              r_wr;
    logic              r_cpu_wait;
    logic              r_ack_prev;
    logic [TW-1:0]     r_base;
    logic [3:0]        r_sec;
    logic [SELW-1:0]   r_sel;

    logic [TW-1:0]     w_track [DRIVES];
    logic [DRIVES-1:0] w_need;
    logic [SELW-1:0]   w_pick;
    logic              w_any;
    logic              w_last;

    always_comb begin
        for (int d = 0; d < DRIVES; d++) begin
            w_track[d] = track[d*TW +: TW];
            w_need[d]  = img_present[d] && (r_mnt_pend[d] || (track[d*TW +: TW] != r_cur_track[d]));
        end
    end

    // Lowest-index drive wins: scan from the top so the last hit is the smallest.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int d = DRIVES - 1; d >= 0; d--) begin
            if (w_need[d]) begin
                w_pick = SELW'(d);
                w_any  = 1'b1;
            end
        end
    end

    assign w_last    = (int'(r_sec) >= SECS - 1);
    assign sd_lba    = 32'(r_base) * 32'(SECS) + 32'(r_sec);
    assign sd_rd     = r_rd;
    assign sd_wr     = r_wr;
    assign drive_sel = r_sel;
    assign track_sec = r_sec;
    assign cpu_wait  = r_cpu_wait;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_loaded   <= '0;
            r_dirty    <= '0;
            r_mnt_pend <= '0;
            r_op_wr    <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_cpu_wait <= 1'b0;
            r_ack_prev <= 1'b0;
            r_base     <= '0;
            r_sec      <= '0;
            r_sel      <= '0;
            for (int d = 0; d < DRIVES; d++) begin
                r_cur_track[d] <= '0;
            end
        end else begin
            r_ack_prev <= sd_ack;
            case (r_state)
                S_IDLE: begin
                    if (w_any) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (!w_any) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_sel   <= w_pick;
                        r_sec   <= '0;
                        r_state <= S_REQ;
                        // A pending mount means the old buffer belongs to a discarded image.
                        if (r_dirty[w_pick] && r_loaded[w_pick] && !r_mnt_pend[w_pick]) begin
                            r_op_wr <= 1'b1;
                            r_base  <= r_cur_track[w_pick];
                        end else begin
                            r_op_wr                <= 1'b0;
                            r_base                 <= w_track[w_pick];
                            r_cur_track[w_pick]    <= w_track[w_pick];
                            r_mnt_pend[w_pick]     <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    r_rd       <= !r_op_wr;
                    r_wr       <= r_op_wr;
                    r_cpu_wait <= 1'b1;
                    r_state    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (sd_ack && !r_ack_prev) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!sd_ack && r_ack_prev) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (!w_last) begin
                        r_sec   <= r_sec + 4'd1;
                        r_state <= S_REQ;
                    end else if (r_op_wr) begin
                        // Write-back done; follow with the read of the track now under the head.
                        r_dirty[r_sel]     <= 1'b0;
                        r_op_wr            <= 1'b0;
                        r_base             <= w_track[r_sel];
                        r_cur_track[r_sel] <= w_track[r_sel];
                        r_mnt_pend[r_sel]  <= 1'b0;
                        r_sec              <= '0;
                        r_state            <= S_REQ;
                    end else begin
                        r_loaded[r_sel] <= img_present[r_sel];
                        r_cpu_wait      <= 1'b0;
                        r_state         <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Per-drive flag updates come last so a mount overrides a same-cycle write or clear.
            for (int d = 0; d < DRIVES; d++) begin
                if (fd_write[d] && r_loaded[d]) r_dirty[d] <= 1'b1;
                if (img_mounted[d]) begin
                    r_mnt_pend[d] <= 1'b1;
                    r_dirty[d]    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_floppy_track_loader.sv
// Directed bench for floppy_track_loader: a 13-sector instance for the main scenarios
// and a 16-sector instance for the top-of-range address case.
module tb_floppy_track_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        sd_ack  = 1'b0;
    logic        use16   = 1'b0;

    logic [11:0] trk0  = '0;
    logic [1:0]  mnt0  = '0;
    logic [1:0]  pres0 = '0;
    logic [1:0]  fdw0  = '0;
    logic [31:0] lba0;
    logic        rd0, wr0, wait0, busy0;
    logic [0:0]  sel0;
    logic [3:0]  sec0;

    logic [11:0] trk16  = '0;
    logic [1:0]  mnt16  = '0;
    logic [1:0]  pres16 = '0;
    logic [1:0]  fdw16  = '0;
    logic [31:0] lba16;
    logic        rd16, wr16, wait16, busy16;
    logic [0:0]  sel16;
    logic [3:0]  sec16;

    logic [31:0] m_lba;
    logic        m_rd, m_wr, m_wait, m_busy;
    logic [0:0]  m_sel;
    logic [3:0]  m_sec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    floppy_track_loader #(.DRIVES(2), .SECS(13), .TW(6)) u0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .track(trk0), .img_mounted(mnt0),
        .img_present(pres0), .fd_write(fdw0), .sd_ack(sd_ack), .sd_lba(lba0),
        .sd_rd(rd0), .sd_wr(wr0), .drive_sel(sel0), .track_sec(sec0),
        .cpu_wait(wait0), .busy(busy0)
    );

    floppy_track_loader #(.DRIVES(2), .SECS(16), .TW(6)) u16 (
        .clk_sys(clk_sys), .reset_n(reset_n), .track(trk16), .img_mounted(mnt16),
        .img_present(pres16), .fd_write(fdw16), .sd_ack(sd_ack), .sd_lba(lba16),
        .sd_rd(rd16), .sd_wr(wr16), .drive_sel(sel16), .track_sec(sec16),
        .cpu_wait(wait16), .busy(busy16)
    );

    always_comb begin
        m_lba  = use16 ? lba16  : lba0;
        m_rd   = use16 ? rd16   : rd0;
        m_wr   = use16 ? wr16   : wr0;
        m_wait = use16 ? wait16 : wait0;
        m_busy = use16 ? busy16 : busy0;
        m_sel  = use16 ? sel16  : sel0;
        m_sec  = use16 ? sec16  : sec0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            if (m_rd || m_wr) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_sector();
        sd_ack = 1'b1;
        @(negedge clk_sys);
        check("req_drop", {30'd0, m_rd, m_wr}, 32'd0);
        check("wait_hold", m_wait, 1);
        @(negedge clk_sys);
        sd_ack = 1'b0;
    endtask

    // Serve sectors first..last of one pass, checking every request against the given base.
    task automatic serve_pass(input bit wr, input int base, input int first, input int last,
                              input int sel);
        bit ok;
        for (int s = first; s <= last; s++) begin
            wait_req(ok);
            if (!ok) return;
            check("req_op", {30'd0, m_rd, m_wr}, wr ? 32'd1 : 32'd2);
            check("lba", m_lba, base + s);
            check("sec", m_sec, s);
            check("sel", m_sel, sel);
            check("cpu_wait", m_wait, 1);
            ack_sector();
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && m_busy; i++) @(negedge clk_sys);
        check("idle", m_busy, 0);
        check("wait_rel", m_wait, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_lba"}, lba0, 0);
        check({tag, "_rdwr"}, {30'd0, rd0, wr0}, 0);
        check({tag, "_wait"}, wait0, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_sec"}, sec0, 0);
        check({tag, "_sel"}, sel0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int cnt;

        repeat (2) @(negedge clk_sys);
        check_outputs_zero("rst");
        reset_n = 1'b1;

        // Clean read of track 5 on drive 0
        pres0 = 2'b01;
        repeat (5) @(negedge clk_sys);
        check("no_need", busy0, 0);
        trk0[5:0] = 6'd5;
        serve_pass(1'b0, 65, 0, 12, 0);
        wait_idle();
        check("loaded0", u0.r_loaded[0], 1);

        // Dirty drive steps to track 6: write back 5, then read 6
        fdw0[0] = 1'b1;
        @(negedge clk_sys);
        fdw0[0] = 1'b0;
        check("dirty_set", u0.r_dirty[0], 1);
        trk0[5:0] = 6'd6;
        serve_pass(1'b1, 65, 0, 12, 0);
        serve_pass(1'b0, 78, 0, 12, 0);
        wait_idle();
        check("dirty_clr", u0.r_dirty[0], 0);

        // Both drives need service together: drive 0 first, then drive 1
        pres0 = 2'b11;
        trk0 = {6'd2, 6'd7};
        serve_pass(1'b0, 91, 0, 12, 0);
        serve_pass(1'b0, 26, 0, 12, 1);
        wait_idle();
        check("loaded1", u0.r_loaded[1], 1);

        // New image on a dirty drive, same track: no write-back, plain re-read
        fdw0[0] = 1'b1;
        @(negedge clk_sys);
        fdw0[0] = 1'b0;
        check("dirty_set2", u0.r_dirty[0], 1);
        mnt0[0] = 1'b1;
        @(negedge clk_sys);
        mnt0[0] = 1'b0;
        check("mnt_clr_dirty", u0.r_dirty[0], 0);
        serve_pass(1'b0, 91, 0, 12, 0);
        wait_idle();

        // Reset in WAIT_LO of sector 4
        trk0[5:0] = 6'd8;
        serve_pass(1'b0, 104, 0, 3, 0);
        wait_req(ok);
        check("sec4_lba", lba0, 108);
        sd_ack = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        sd_ack = 1'b0;
        pres0  = 2'b00;
        @(negedge clk_sys);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (rd0 || wr0) cnt++;
        end
        check("no_req_after_rst", cnt, 0);
        pres0 = 2'b01;
        serve_pass(1'b0, 104, 0, 12, 0);
        wait_idle();

        // 16 sectors per track at track 63: addresses 1008..1023
        use16 = 1'b1;
        pres16 = 2'b01;
        trk16[5:0] = 6'd63;
        serve_pass(1'b0, 1008, 0, 15, 0);
        wait_idle();
        check("sec16_final", sec16, 15);
        check("lba16_final", lba16, 1023);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
